// File: rtl/riscv_mem_arbiter_pkg.sv
// rtl/riscv_mem_arbiter_pkg.sv - shared owner encodings and constants for the IF/DM memory arbiter
package riscv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int WORD_OFS = 2;
    localparam int PERF_W   = 32;

endpackage

// File: rtl/riscv_arb_perf.sv
// rtl/riscv_arb_perf.sv - arbiter event counter bank, instantiated only when RISCV_ARB_PERF_EN is defined
module riscv_arb_perf
    import riscv_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_wait,
    input  logic              dm_wait,
    input  logic              conflict,
    input  logic              starve_force,
    output logic [PERF_W-1:0] perf_if_wait,
    output logic [PERF_W-1:0] perf_dm_wait,
    output logic [PERF_W-1:0] perf_conflict,
    output logic [PERF_W-1:0] perf_starve_force
);

    // Counters wrap naturally at 2**PERF_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_wait      <= '0;
            perf_dm_wait      <= '0;
            perf_conflict     <= '0;
            perf_starve_force <= '0;
        end else begin
            if (if_wait)      perf_if_wait      <= perf_if_wait + 1'b1;
            if (dm_wait)      perf_dm_wait      <= perf_dm_wait + 1'b1;
            if (conflict)     perf_conflict     <= perf_conflict + 1'b1;
            if (starve_force) perf_starve_force <= perf_starve_force + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - IF/DM arbiter for one single-port memory; optional counters via RISCV_ARB_PERF_EN
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_AW       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_wstrb,
    output logic              dm_gnt,
    output logic              dm_stall,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
`ifdef RISCV_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_if_wait,
    output logic [PERF_W-1:0] perf_dm_wait,
    output logic [PERF_W-1:0] perf_conflict,
    output logic [PERF_W-1:0] perf_starve_force
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    owner_t        owner_q;
    logic [SW-1:0] starve_cnt;
    logic          err_q;
    logic          if_req_v;
    logic          dm_req_v;
    logic          dm_oor;
    logic          if_force;
    logic          unused_addr_bits;

    // Requests are masked while reset is high so every output is 0 immediately.
    assign if_req_v = if_req & ~rst;
    assign dm_req_v = dm_req & ~rst;
    assign dm_oor   = |dm_addr[ADDR_W-1:MEM_AW+WORD_OFS];
    assign if_force = (starve_cnt == SW'(STARVE_LIMIT));

    assign if_gnt   = if_req_v & ~if_flush & (~dm_req_v | if_force);
    assign dm_gnt   = dm_req_v & ~if_gnt;
    assign if_stall = if_req_v & ~if_gnt;
    assign dm_stall = dm_req_v & ~dm_gnt;

    assign mem_en    = if_gnt | (dm_gnt & ~dm_oor);
    assign mem_we    = dm_gnt & ~dm_oor & dm_we;
    assign mem_addr  = if_gnt ? if_addr[MEM_AW+WORD_OFS-1:WORD_OFS] :
                       dm_gnt ? dm_addr[MEM_AW+WORD_OFS-1:WORD_OFS] : '0;
    assign mem_wdata = mem_we ? dm_wdata : '0;
    assign mem_wstrb = mem_we ? dm_wstrb : '0;

    assign if_rvalid = (owner_q == OWN_IF) & ~if_flush;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rvalid = (owner_q == OWN_DM);
    assign dm_rdata  = (dm_rvalid & ~err_q) ? mem_rdata : '0;
    assign dm_err    = err_q;

    assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+WORD_OFS], if_addr[1:0], dm_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            if (if_gnt)
                owner_q <= OWN_IF;
            else if (dm_gnt & ~dm_we)
                owner_q <= OWN_DM;
            else
                owner_q <= OWN_NONE;
            err_q <= dm_gnt & dm_oor;
            if (if_req_v & ~if_gnt) begin
                if (!if_force)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`ifdef RISCV_ARB_PERF_EN
    riscv_arb_perf u_perf (
        .clk               (clk),
        .rst               (rst),
        .if_wait           (if_stall),
        .dm_wait           (dm_stall),
        .conflict          (if_req_v & dm_req_v),
        .starve_force      (if_gnt & dm_req_v & if_force),
        .perf_if_wait      (perf_if_wait),
        .perf_dm_wait      (perf_dm_wait),
        .perf_conflict     (perf_conflict),
        .perf_starve_force (perf_starve_force)
    );
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench for riscv_mem_arbiter with a 1-cycle memory model
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        if_gnt, if_stall, if_rvalid, dm_gnt, dm_stall, dm_rvalid, dm_err;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef RISCV_ARB_PERF_EN
    logic [31:0] perf_if_wait, perf_dm_wait, perf_conflict, perf_starve_force;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] if_q[$];
    logic [32:0] dm_q[$];

    logic [31:0] mem [0:1023];
    bit          mem_ready = 1'b0;

    riscv_mem_arbiter #(.ADDR_W(32), .MEM_AW(10), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_stall(if_stall), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_gnt(dm_gnt), .dm_stall(dm_stall), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef RISCV_ARB_PERF_EN
        , .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait),
        .perf_conflict(perf_conflict), .perf_starve_force(perf_starve_force)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 | i;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) chk("if_unexpected_rvalid", 1, 0);
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_rvalid) begin
                if (dm_q.size() == 0) chk("dm_unexpected_rvalid", 1, 0);
                else chk("dm_resp", {dm_err, dm_rdata}, dm_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int          first_if;
    int          dm_stalls;
    logic [31:0] t1_addr [4];
    int          t1_word [4];

    initial begin
        rst = 1'b1; if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
        t1_addr = '{32'h0, 32'h4, 32'h8, 32'h8000_0008};
        t1_word = '{0, 1, 2, 2};
        repeat (2) next_cycle();
        if_req = 1; dm_req = 1;
        @(negedge clk);
        chk("rst_outputs", {if_gnt, if_stall, if_rvalid, dm_gnt, dm_stall, dm_rvalid, dm_err, mem_en, mem_we}, 0);
        next_cycle();
        rst = 0; if_req = 0; dm_req = 0;
        next_cycle();

        // IF-only back-to-back fetches, including an upper-bit wrap
        for (int i = 0; i < 4; i++) begin
            if_req = 1; if_addr = t1_addr[i];
            @(negedge clk);
            chk("t1_if_gnt", {if_gnt, if_stall}, 2'b10);
            if (if_gnt) if_q.push_back(init_word(t1_word[i]));
            next_cycle();
        end
        if_req = 0;
        next_cycle();

        // Conflict: DM wins, IF follows
        if_req = 1; if_addr = 32'hC; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        chk("t2_conflict", {dm_gnt, if_gnt, if_stall}, 3'b101);
        if (dm_gnt) dm_q.push_back({1'b0, init_word(64)});
        next_cycle();
        dm_req = 0;
        @(negedge clk);
        chk("t2_if_after", if_gnt, 1);
        if (if_gnt) if_q.push_back(init_word(3));
        next_cycle();
        if_req = 0;
        next_cycle();

        // Starvation: DM held for 10 cycles
        first_if = -1; dm_stalls = 0;
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_exclusive", {if_gnt, dm_gnt} == 2'b01 || {if_gnt, dm_gnt} == 2'b10, 1);
            if (if_gnt) begin
                if (first_if < 0) first_if = c;
                if_q.push_back(init_word(4));
            end
            if (dm_gnt) dm_q.push_back({1'b0, init_word(8)});
            else dm_stalls++;
            next_cycle();
        end
        chk("t3_first_if_gnt", first_if, 4);
        chk("t3_dm_stalls", dm_stalls, 2);
        if_req = 0; dm_req = 0;
        next_cycle();

        // Flush after an IF grant, with a DM read in the flush cycle
        if_req = 1; if_addr = 32'h14;
        @(negedge clk);
        chk("t4_if_gnt", if_gnt, 1);
        next_cycle();
        if_flush = 1; if_addr = 32'h18; dm_req = 1; dm_we = 0; dm_addr = 32'h24;
        @(negedge clk);
        chk("t4_flush", {if_rvalid, if_gnt, dm_gnt}, 3'b001);
        if (dm_gnt) dm_q.push_back({1'b0, init_word(9)});
        next_cycle();
        if_flush = 0; if_req = 0; dm_req = 0;
        next_cycle();

        // Partial write, read-back, out-of-range read and write
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hAABBCCDD; dm_wstrb = 4'b0011;
        @(negedge clk);
        chk("t5_wr_gnt", {dm_gnt, mem_we}, 2'b11);
        next_cycle();
        dm_we = 0;
        @(negedge clk);
        chk("t5_wr_ack", {dm_rvalid, dm_err}, 0);
        dm_q.push_back({1'b0, 32'hC0DE_CCDD});
        next_cycle();
        dm_addr = 32'h1000_0000;
        @(negedge clk);
        chk("t5_oor_rd", {dm_gnt, mem_en}, 2'b10);
        dm_q.push_back({1'b1, 32'h0});
        next_cycle();
        dm_we = 1; dm_addr = 32'h1000_0040; dm_wdata = 32'hFFFF_FFFF; dm_wstrb = 4'hF;
        @(negedge clk);
        chk("t5_oor_wr", {dm_gnt, mem_en}, 2'b10);
        next_cycle();
        dm_we = 0; dm_addr = 32'h40;
        @(negedge clk);
        chk("t5_oor_wr_err", {dm_err, dm_rvalid}, 2'b10);
        dm_q.push_back({1'b0, 32'hC0DE_CCDD});
        next_cycle();
        dm_req = 0;
        next_cycle();

        // Reset with a DM read in flight
        dm_req = 1; dm_we = 0; dm_addr = 32'h44;
        @(negedge clk);
        chk("t6_gnt", dm_gnt, 1);
        next_cycle();
        rst = 1; if_req = 1;
        @(negedge clk);
        chk("t6_rst_outputs", {if_gnt, if_stall, if_rvalid, dm_gnt, dm_stall, dm_rvalid, dm_err, mem_en, mem_we}, 0);
        chk("t6_rst_data", {if_rdata, dm_rdata}, 0);
        next_cycle();
        if_req = 0; dm_req = 0;
        next_cycle();
        rst = 0;
        repeat (3) next_cycle();

        chk("queues_drained", {if_q.size(), dm_q.size()}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
